// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with dual write, bypass, zero register and busy scoreboard
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  wr0_hit;
  logic [DEPTH-1:0]  wr1_hit;
  logic [DEPTH-1:0]  claim_hit;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              claim_ok;
  logic              conflict_next;

  // Accesses to a hardwired zero register are dropped before decode.
  always_comb begin
    wr0_ok        = wr0_en   && !(ZERO_REG && (wr0_addr == '0));
    wr1_ok        = wr1_en   && !(ZERO_REG && (wr1_addr == '0));
    claim_ok      = claim_en && !(ZERO_REG && (claim_addr == '0));
    conflict_next = wr0_ok && wr1_ok && (wr0_addr == wr1_addr);
    wr0_hit       = '0;
    wr1_hit       = '0;
    claim_hit     = '0;
    wr0_hit[wr0_addr]     = wr0_ok;
    wr1_hit[wr1_addr]     = wr1_ok;
    claim_hit[claim_addr] = claim_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr1_hit[i])      regs[i] <= wr1_data;
        else if (wr0_hit[i]) regs[i] <= wr0_data;
      end
      // A claim on the writeback edge wins so back-to-back producers stay tracked.
      busy        <= claim_hit | (busy & ~(wr0_hit | wr1_hit));
      wr_conflict <= conflict_next;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (ZERO_REG && (ra == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end else if (BYPASS && wr1_en && (wr1_addr == ra)) begin
        rd_data[k*DATA_W +: DATA_W] = wr1_data;
        rd_busy[k]                  = 1'b0;
      end else if (BYPASS && wr0_en && (wr0_addr == ra)) begin
        rd_data[k*DATA_W +: DATA_W] = wr0_data;
        rd_busy[k]                  = 1'b0;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regs[ra];
        rd_busy[k]                  = busy[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // a: defaults, b: no bypass, c: 16-bit x 8 with four read ports
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr0_en, a_wr1_en, a_claim_en, a_conf;
  logic [4:0]  a_wr0_addr, a_wr1_addr, a_claim_addr;
  logic [31:0] a_wr0_data, a_wr1_data;

  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic        b_wr0_en, b_wr1_en, b_claim_en, b_conf;
  logic [4:0]  b_wr0_addr, b_wr1_addr, b_claim_addr;
  logic [31:0] b_wr0_data, b_wr1_data;

  logic [11:0] c_rd_addr;
  logic [63:0] c_rd_data;
  logic [3:0]  c_rd_busy;
  logic        c_wr0_en, c_wr1_en, c_claim_en, c_conf;
  logic [2:0]  c_wr0_addr, c_wr1_addr, c_claim_addr;
  logic [15:0] c_wr0_data, c_wr1_data;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr0_en(a_wr0_en), .wr0_addr(a_wr0_addr), .wr0_data(a_wr0_data),
    .wr1_en(a_wr1_en), .wr1_addr(a_wr1_addr), .wr1_data(a_wr1_data),
    .claim_en(a_claim_en), .claim_addr(a_claim_addr), .wr_conflict(a_conf)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
    .claim_en(b_claim_en), .claim_addr(b_claim_addr), .wr_conflict(b_conf)
  );

  regfile_mp #(.DATA_W(16), .DEPTH(8), .NUM_RD(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr0_en(c_wr0_en), .wr0_addr(c_wr0_addr), .wr0_data(c_wr0_data),
    .wr1_en(c_wr1_en), .wr1_addr(c_wr1_addr), .wr1_data(c_wr1_data),
    .claim_en(c_claim_en), .claim_addr(c_claim_addr), .wr_conflict(c_conf)
  );

  task automatic idle_all;
    a_wr0_en = 0; a_wr1_en = 0; a_claim_en = 0;
    b_wr0_en = 0; b_wr1_en = 0; b_claim_en = 0;
    c_wr0_en = 0; c_wr1_en = 0; c_claim_en = 0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rd_addr = {5'd7, 5'd5};
    #1;
    n_cmp++; if (a_rd_data !== 64'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", a_rd_data); end
    n_cmp++; if (a_rd_busy !== 2'b00) begin n_err++; $display("FAIL reset_busy got=%b exp=00", a_rd_busy); end
    n_cmp++; if (a_conf !== 1'b0) begin n_err++; $display("FAIL reset_conflict got=%b exp=0", a_conf); end
    n_cmp++; if (c_rd_data !== 64'd0) begin n_err++; $display("FAIL reset_data_c got=%h exp=0", c_rd_data); end
    tick;
    rst_n = 1'b1;
    a_wr0_en = 1; a_wr0_addr = 5'd5; a_wr0_data = 32'hDEADBEEF;
    a_claim_en = 1; a_claim_addr = 5'd7;
    tick;
    idle_all;
    #1;
    n_cmp++; if (a_rd_data[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_reset_r5 got=%h exp=deadbeef", a_rd_data[31:0]); end
    n_cmp++; if (a_rd_busy[1] !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy_r7 got=%b exp=1", a_rd_busy[1]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_rd_data[31:0] !== 32'd0) begin n_err++; $display("FAIL async_reset_r5 got=%h exp=0", a_rd_data[31:0]); end
    n_cmp++; if (a_rd_busy[1] !== 1'b0) begin n_err++; $display("FAIL async_reset_busy_r7 got=%b exp=0", a_rd_busy[1]); end
    a_wr0_en = 1; a_wr0_addr = 5'd5; a_wr0_data = 32'h1;
    a_claim_en = 1; a_claim_addr = 5'd7;
    tick;
    rst_n = 1'b1;
    idle_all;
    #1;
    n_cmp++; if (a_rd_data[31:0] !== 32'd0) begin n_err++; $display("FAIL reset_discard_write got=%h exp=0", a_rd_data[31:0]); end
    n_cmp++; if (a_rd_busy[1] !== 1'b0) begin n_err++; $display("FAIL reset_discard_claim got=%b exp=0", a_rd_busy[1]); end
  endtask

  task automatic test_dual_write;
    a_wr0_en = 1; a_wr0_addr = 5'd3; a_wr0_data = 32'h11;
    a_wr1_en = 1; a_wr1_addr = 5'd4; a_wr1_data = 32'h22;
    tick;
    idle_all;
    a_rd_addr = {5'd4, 5'd3};
    #1;
    n_cmp++; if (a_rd_data !== {32'h22, 32'h11}) begin n_err++; $display("FAIL dual_write got=%h exp=%h", a_rd_data, {32'h22, 32'h11}); end
    n_cmp++; if (a_conf !== 1'b0) begin n_err++; $display("FAIL no_conflict got=%b exp=0", a_conf); end
    a_wr0_en = 1; a_wr0_addr = 5'd6; a_wr0_data = 32'hAA;
    a_wr1_en = 1; a_wr1_addr = 5'd6; a_wr1_data = 32'hBB;
    tick;
    idle_all;
    a_rd_addr = {5'd6, 5'd6};
    #1;
    n_cmp++; if (a_rd_data[31:0] !== 32'hBB) begin n_err++; $display("FAIL wr1_priority got=%h exp=bb", a_rd_data[31:0]); end
    n_cmp++; if (a_conf !== 1'b1) begin n_err++; $display("FAIL conflict_set got=%b exp=1", a_conf); end
    tick;
    n_cmp++; if (a_conf !== 1'b0) begin n_err++; $display("FAIL conflict_one_cycle got=%b exp=0", a_conf); end
  endtask

  task automatic test_bypass;
    a_wr0_en = 1; a_wr0_addr = 5'd9; a_wr0_data = 32'h5;
    b_wr0_en = 1; b_wr0_addr = 5'd9; b_wr0_data = 32'h5;
    tick;
    idle_all;
    a_rd_addr = {5'd9, 5'd0};
    b_rd_addr = {5'd9, 5'd0};
    a_wr1_en = 1; a_wr1_addr = 5'd9; a_wr1_data = 32'h77;
    b_wr1_en = 1; b_wr1_addr = 5'd9; b_wr1_data = 32'h77;
    #1;
    n_cmp++; if (a_rd_data[63:32] !== 32'h77) begin n_err++; $display("FAIL bypass_on got=%h exp=77", a_rd_data[63:32]); end
    n_cmp++; if (b_rd_data[63:32] !== 32'h5) begin n_err++; $display("FAIL bypass_off_before got=%h exp=5", b_rd_data[63:32]); end
    tick;
    idle_all;
    #1;
    n_cmp++; if (b_rd_data[63:32] !== 32'h77) begin n_err++; $display("FAIL bypass_off_after got=%h exp=77", b_rd_data[63:32]); end
    n_cmp++; if (a_rd_data[63:32] !== 32'h77) begin n_err++; $display("FAIL bypass_on_stored got=%h exp=77", a_rd_data[63:32]); end
    a_rd_addr = {5'd10, 5'd10};
    a_wr0_en = 1; a_wr0_addr = 5'd10; a_wr0_data = 32'h1;
    #1;
    n_cmp++; if (a_rd_data[31:0] !== 32'h1) begin n_err++; $display("FAIL bypass_wr0 got=%h exp=1", a_rd_data[31:0]); end
    a_wr1_en = 1; a_wr1_addr = 5'd10; a_wr1_data = 32'h2;
    #1;
    n_cmp++; if (a_rd_data[31:0] !== 32'h2) begin n_err++; $display("FAIL bypass_wr1_over_wr0 got=%h exp=2", a_rd_data[31:0]); end
    idle_all;
  endtask

  task automatic test_zero_reg;
    a_rd_addr = {5'd0, 5'd0};
    a_wr0_en = 1; a_wr0_addr = 5'd0; a_wr0_data = 32'hFFFFFFFF;
    a_claim_en = 1; a_claim_addr = 5'd0;
    #1;
    n_cmp++; if (a_rd_data !== 64'd0) begin n_err++; $display("FAIL zero_no_bypass got=%h exp=0", a_rd_data); end
    tick;
    a_claim_en = 0;
    a_wr1_en = 1; a_wr1_addr = 5'd0; a_wr1_data = 32'h12345678;
    #1;
    n_cmp++; if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00) begin n_err++; $display("FAIL zero_after_write got=%h/%b exp=0/00", a_rd_data, a_rd_busy); end
    tick;
    idle_all;
    #1;
    n_cmp++; if (a_conf !== 1'b0) begin n_err++; $display("FAIL zero_conflict got=%b exp=0", a_conf); end
    n_cmp++; if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00) begin n_err++; $display("FAIL zero_final got=%h/%b exp=0/00", a_rd_data, a_rd_busy); end
  endtask

  task automatic test_scoreboard;
    a_rd_addr = {5'd0, 5'd12};
    b_rd_addr = {5'd0, 5'd12};
    a_claim_en = 1; a_claim_addr = 5'd12;
    b_claim_en = 1; b_claim_addr = 5'd12;
    tick;
    idle_all;
    #1;
    n_cmp++; if (a_rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL claim_busy got=%b exp=1", a_rd_busy[0]); end
    a_wr0_en = 1; a_wr0_addr = 5'd12; a_wr0_data = 32'h3;
    b_wr0_en = 1; b_wr0_addr = 5'd12; b_wr0_data = 32'h3;
    #1;
    n_cmp++; if (a_rd_data[31:0] !== 32'h3 || a_rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL bypass_hides_busy got=%h/%b exp=3/0", a_rd_data[31:0], a_rd_busy[0]); end
    n_cmp++; if (b_rd_data[31:0] !== 32'h0 || b_rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL nobypass_busy_write_cycle got=%h/%b exp=0/1", b_rd_data[31:0], b_rd_busy[0]); end
    tick;
    idle_all;
    #1;
    n_cmp++; if (a_rd_data[31:0] !== 32'h3 || a_rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL write_clears_busy got=%h/%b exp=3/0", a_rd_data[31:0], a_rd_busy[0]); end
    n_cmp++; if (b_rd_data[31:0] !== 32'h3 || b_rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL nobypass_cleared got=%h/%b exp=3/0", b_rd_data[31:0], b_rd_busy[0]); end
    a_claim_en = 1; a_claim_addr = 5'd12;
    a_wr1_en = 1; a_wr1_addr = 5'd12; a_wr1_data = 32'h4;
    tick;
    idle_all;
    #1;
    n_cmp++; if (a_rd_busy[0] !== 1'b1 || a_rd_data[31:0] !== 32'h4) begin n_err++; $display("FAIL claim_wins got=%b/%h exp=1/4", a_rd_busy[0], a_rd_data[31:0]); end
    a_claim_en = 1; a_claim_addr = 5'd12;
    tick;
    idle_all;
    #1;
    n_cmp++; if (a_rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL reclaim_busy got=%b exp=1", a_rd_busy[0]); end
  endtask

  task automatic test_param;
    logic [15:0] exp_c [8];
    logic [2:0]  cnt;
    logic [2:0]  ak;
    exp_c = '{16'h0000, 16'h0F0F, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hABCD};
    c_wr0_en = 1; c_wr0_addr = 3'd2; c_wr0_data = 16'h1234;
    c_wr1_en = 1; c_wr1_addr = 3'd7; c_wr1_data = 16'hABCD;
    tick;
    c_wr1_en = 0;
    c_wr0_addr = 3'd1; c_wr0_data = 16'h0F0F;
    tick;
    idle_all;
    c_rd_addr = {3'd0, 3'd1, 3'd7, 3'd2};
    #1;
    n_cmp++; if (c_rd_data[15:0] !== 16'h1234) begin n_err++; $display("FAIL param_p0_r2 got=%h exp=1234", c_rd_data[15:0]); end
    n_cmp++; if (c_rd_data[31:16] !== 16'hABCD) begin n_err++; $display("FAIL param_p1_r7 got=%h exp=abcd", c_rd_data[31:16]); end
    n_cmp++; if (c_rd_data[47:32] !== 16'h0F0F) begin n_err++; $display("FAIL param_p2_r1 got=%h exp=0f0f", c_rd_data[47:32]); end
    n_cmp++; if (c_rd_data[63:48] !== 16'h0000) begin n_err++; $display("FAIL param_p3_r0 got=%h exp=0", c_rd_data[63:48]); end
    n_cmp++; if (c_rd_busy !== 4'b0000) begin n_err++; $display("FAIL param_busy got=%b exp=0000", c_rd_busy); end
    cnt = 3'd0;
    for (int s = 0; s < 9; s++) begin
      for (int k = 0; k < 4; k++) c_rd_addr[k*3 +: 3] = cnt + 3'(k);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        ak = cnt + 3'(k);
        n_cmp++;
        if (c_rd_data[k*16 +: 16] !== exp_c[ak]) begin
          n_err++;
          $display("FAIL sweep step=%0d port=%0d addr=%0d got=%h exp=%h", s, k, ak, c_rd_data[k*16 +: 16], exp_c[ak]);
        end
      end
      cnt = cnt + 3'd1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_rd_addr = '0; b_rd_addr = '0; c_rd_addr = '0;
    a_wr0_addr = '0; a_wr1_addr = '0; a_claim_addr = '0; a_wr0_data = '0; a_wr1_data = '0;
    b_wr0_addr = '0; b_wr1_addr = '0; b_claim_addr = '0; b_wr0_data = '0; b_wr1_data = '0;
    c_wr0_addr = '0; c_wr1_addr = '0; c_claim_addr = '0; c_wr0_data = '0; c_wr1_data = '0;
    idle_all;
    test_reset;
    test_dual_write;
    test_bypass;
    test_zero_reg;
    test_scoreboard;
    test_param;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the datapath. It replaces the fixed 32x32, two-read/one-write file with configurable width, depth and read-port count, and adds:
- a second write port;
- write-to-read bypass;
- an optional hardwired zero register;
- a per-register busy scoreboard that lets issue logic detect pending writebacks.

All state is cleared by asynchronous reset.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, >= 2)
- ADDR_W, $clog2(DEPTH), address width (derived)
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes, never busy

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing
- rd_busy  out  NUM_RD  per-port busy flag for the addressed register
- wr0_en  in  1  write port 0 enable
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (higher priority)
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- claim_en  in  1  mark a register as awaiting writeback
- claim_addr  in  ADDR_W  register to claim
- wr_conflict  out  1  registered pulse: both ports wrote the same address last cycle

## Operation
- Storage: DEPTH x DATA_W registers plus DEPTH busy bits.
- Writes:
  - On a rising edge, each enabled write port updates its addressed register.
  - If wr0_en and wr1_en target the same address, wr1 wins and wr0 is discarded.
  - In that same-address case, wr_conflict is set to 1 for exactly the following cycle; otherwise it is 0.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are ignored and never raise wr_conflict.
  - Claims of address 0 are ignored.
  - Reads of address 0 return 0 with rd_busy=0.
- Reads: combinational, per port, evaluated in this priority order:
  - ZERO_REG and addr==0 -> data 0, busy 0.
  - BYPASS and wr1_en and wr1_addr==addr -> data wr1_data, busy 0.
  - BYPASS and wr0_en and wr0_addr==addr -> data wr0_data, busy 0.
  - Otherwise -> stored data and stored busy bit.
  - With BYPASS=0, reads return only stored state; new data is visible the cycle after the write.
- Scoreboard (per-register busy bit):
  - Cleared on an edge where any write port writes that register.
  - Set on an edge where claim_en targets that register.
  - Claim and write to the same register on the same edge: busy ends 1 (claim wins; models back-to-back producers).
  - Claiming an already-busy register keeps it 1.
  - Writing a non-busy register is legal and leaves it 0.

## Timing
- Reset (rst_n low), applied asynchronously and immediately:
  - all registers = 0, all busy = 0, wr_conflict = 0.
  - Therefore rd_data = 0 and rd_busy = 0 for every address.
  - Reset asserted mid-operation discards any write or claim on that edge.
  - The first write is accepted on the first rising edge after rst_n is sampled high.
- Latencies:
  - Write latency 1 edge.
  - Read latency 0 (combinational from rd_addr and write inputs).
  - Busy set and clear take effect at the next edge; bypass hides the clear in the write cycle.
  - wr_conflict is registered: high for one cycle after the conflicting edge.
- No handshakes: ports are always ready; claim and write may be asserted every cycle.
- Addresses are used as-is. No out-of-range condition exists, because DEPTH is a power of two.

## Test plan
- Reset: write 0xDEADBEEF to r5, claim r7, then pulse rst_n low between edges -> r5 reads 0 and rd_busy for r7 = 0 immediately, before the next clock edge.
- Dual write and conflict:
  - wr0 r3=0x11 and wr1 r4=0x22 on one edge -> next cycle r3=0x11, r4=0x22, wr_conflict=0.
  - Then wr0 r6=0xAA and wr1 r6=0xBB -> r6=0xBB, wr_conflict=1 for one cycle only.
- Bypass (BYPASS=1): r9 holds 0x5, wr1 r9=0x77 with rd_addr port1=r9 in the same cycle -> rd_data=0x77 before the edge. With BYPASS=0 -> 0x5 before the edge and 0x77 after.
- Zero register: wr0 r0=0xFFFFFFFF, claim r0, and wr0 plus wr1 both to r0 -> all ports read r0 as 0, rd_busy=0, wr_conflict stays 0.
- Scoreboard:
  - claim r12 -> rd_busy=1 next cycle.
  - Write r12=0x3 -> bypass shows data 0x3 with busy 0 during the write cycle; stored busy is 0 after the edge.
  - Claim r12 and write r12 on the same edge -> busy remains 1.
- Parametrisation: DATA_W=16, DEPTH=8, NUM_RD=4 -> write 0x1234 to r2, 0xABCD to r7, 0x0F0F to r1 -> all four ports read r2, r7, r1 and r0 correctly and independently in the same cycle, including after wrap of a 3-bit address counter sweep 0..7..0.
